// File: rtl/clk_div_ctrl.sv
// Run/stop and ratio controller: 50%-duty divided clock with rise/fall strobes and a
// half-period reloadable at falling edges. Optional macro CLK_DIV_CTRL_CFG_ERR_EN adds cfg_err.
module clk_div_ctrl #(
  parameter int HALF_W   = 8,
  parameter int HALF_DEF = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  input  logic [HALF_W-1:0] cfg_half,
  output logic              cfg_ready,
`ifdef CLK_DIV_CTRL_CFG_ERR_EN
  output logic              cfg_err,
`endif
  output logic              clk_div,
  output logic              div_rise_stb,
  output logic              div_fall_stb,
  output logic              running,
  output logic [HALF_W-1:0] cur_half
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [HALF_W-1:0] cnt;
  logic [HALF_W-1:0] pend_half;
  logic              pend_valid;
  logic              active;
  logic              term;
  logic              quit_low;
  logic              toggle;
  logic              fall_now;
  logic              cfg_zero;
  logic              accept;
  logic              take;
  logic              apply;

  assign active   = (state != IDLE);
  assign term     = (cnt == cur_half - HALF_W'(1));
  // Stopping while low abandons the low phase outright, so no extra rising edge escapes.
  assign quit_low = (state == STOPPING) && !en && !clk_div;
  assign toggle   = active && term && !quit_low;
  assign fall_now = toggle && clk_div;
  assign cfg_zero = (cfg_half == '0);
  assign accept   = cfg_valid && cfg_ready;
`ifdef CLK_DIV_CTRL_CFG_ERR_EN
  assign take     = accept && !cfg_zero;
`else
  assign take     = accept;
`endif
  // A pending value only lands while idle or on a 1->0 toggle, so phases never get cut short.
  assign apply    = pend_valid && ((state == IDLE) || fall_now);

  // NOTE: state_nxt gets a default before the case, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (en) state_nxt = RUN;
      RUN:      if (!en) state_nxt = STOPPING;
      STOPPING: begin
        if (en)                         state_nxt = RUN;
        else if (quit_low || fall_now)  state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      clk_div      <= 1'b0;
      div_rise_stb <= 1'b0;
      div_fall_stb <= 1'b0;
      running      <= 1'b0;
      cfg_ready    <= 1'b1;
      cur_half     <= HALF_W'(HALF_DEF);
      pend_half    <= '0;
      pend_valid   <= 1'b0;
`ifdef CLK_DIV_CTRL_CFG_ERR_EN
      cfg_err      <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      running      <= (state_nxt != IDLE);
      div_rise_stb <= toggle && !clk_div;
      div_fall_stb <= fall_now;

      if (!active || quit_low || term) cnt <= '0;
      else                             cnt <= cnt + HALF_W'(1);

      if (toggle) clk_div <= !clk_div;

      if (apply) begin
        cur_half   <= pend_half;
        pend_valid <= 1'b0;
        cfg_ready  <= 1'b1;
      end else if (take) begin
        pend_half  <= cfg_zero ? HALF_W'(1) : cfg_half;
        pend_valid <= 1'b1;
        cfg_ready  <= 1'b0;
      end

`ifdef CLK_DIV_CTRL_CFG_ERR_EN
      cfg_err <= accept && cfg_zero;
`endif
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: expected clk_div/strobe waveforms are queued per
// scenario and popped by a negedge monitor; handshake and status checks are inline per task.
module tb_clk_div_ctrl;

  localparam int HALF_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [HALF_W-1:0] cfg_half = '0;
  logic              cfg_ready;
`ifdef CLK_DIV_CTRL_CFG_ERR_EN
  logic              cfg_err;
`endif
  logic              clk_div;
  logic              div_rise_stb;
  logic              div_fall_stb;
  logic              running;
  logic [HALF_W-1:0] cur_half;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic d;
    logic r;
    logic f;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   phase_q[$];

  clk_div_ctrl #(.HALF_W(HALF_W), .HALF_DEF(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_half     (cfg_half),
    .cfg_ready    (cfg_ready),
`ifdef CLK_DIV_CTRL_CFG_ERR_EN
    .cfg_err      (cfg_err),
`endif
    .clk_div      (clk_div),
    .div_rise_stb (div_rise_stb),
    .div_fall_stb (div_fall_stb),
    .running      (running),
    .cur_half     (cur_half)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Scoreboard: one expected waveform sample consumed per cycle while entries remain.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({clk_div, div_rise_stb, div_fall_stb} !== {mon_e.d, mon_e.r, mon_e.f}) begin
        failures++;
        $display("FAIL wave t=%0t got div/rise/fall=%b%b%b want=%b%b%b", $time,
                 clk_div, div_rise_stb, div_fall_stb, mon_e.d, mon_e.r, mon_e.f);
      end
    end
  end

  // Phases alternate low/high starting low from idle; every phase after the first opens with an edge.
  task automatic push_wave();
    exp_t e;
    foreach (phase_q[i]) begin
      for (int j = 0; j < phase_q[i]; j++) begin
        e.d = ((i % 2) == 1);
        e.r = (j == 0) && (i > 0) && ((i % 2) == 1);
        e.f = (j == 0) && (i > 0) && ((i % 2) == 0);
        exp_q.push_back(e);
      end
    end
    phase_q.delete();
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    int n;
    n = 0;
    en = 1'b0;
    cfg_valid = 1'b0;
    while ((running !== 1'b0 || clk_div !== 1'b0) && n < 40) begin
      next_cyc();
      n++;
    end
    checks++;
    if (n >= 40) begin
      failures++;
      $display("FAIL stop_timeout running=%b clk_div=%b after %0d cycles", running, clk_div, n);
    end
    next_cyc();
    next_cyc();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({clk_div, div_rise_stb, div_fall_stb, running, cfg_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL reset_outputs got div/rise/fall/run/ready=%b%b%b%b%b want=00001",
               clk_div, div_rise_stb, div_fall_stb, running, cfg_ready);
    end
    checks++;
    if (cur_half !== 8'd4) begin
      failures++;
      $display("FAIL reset_cur_half got=%0d want=4", cur_half);
    end
`ifdef CLK_DIV_CTRL_CFG_ERR_EN
    checks++;
    if (cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_cfg_err got=%b want=0", cfg_err);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    next_cyc();
    next_cyc();
  endtask

  task automatic test_run_basic();
    phase_q = {5, 4, 4, 4, 4};
    push_wave();
    for (int k = 0; k < 21; k++) begin
      if (k == 0) en = 1'b1;
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (running !== 1'b0) begin
          failures++;
          $display("FAIL basic_running_idle got=%b want=0", running);
        end
      end
      if (k == 1) begin
        checks++;
        if (running !== 1'b1) begin
          failures++;
          $display("FAIL basic_running_run got=%b want=1", running);
        end
      end
      next_cyc();
    end
    go_idle();
  endtask

  task automatic load_half(input logic [HALF_W-1:0] v);
    cfg_half = v;
    cfg_valid = 1'b1;
    next_cyc();
    cfg_valid = 1'b0;
    next_cyc();
    next_cyc();
    checks++;
    if (cur_half !== v || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_load got cur_half=%0d ready=%b want %0d/1", cur_half, cfg_ready, v);
    end
  endtask

  task automatic test_cfg_during_high();
    phase_q = {5, 4, 2, 2, 2, 2};
    push_wave();
    for (int k = 0; k < 17; k++) begin
      if (k == 0) en = 1'b1;
      if (k == 6) begin
        cfg_half = 8'd2;
        cfg_valid = 1'b1;
      end
      if (k == 7) cfg_valid = 1'b0;
      @(negedge clk);
      if (k == 7 || k == 8) begin
        checks++;
        if (cfg_ready !== 1'b0) begin
          failures++;
          $display("FAIL pend_ready cyc=%0d got=%b want=0", k, cfg_ready);
        end
      end
      if (k == 8) begin
        checks++;
        if (cur_half !== 8'd4) begin
          failures++;
          $display("FAIL early_apply got cur_half=%0d want=4", cur_half);
        end
      end
      if (k == 9) begin
        checks++;
        if (cfg_ready !== 1'b1 || cur_half !== 8'd2) begin
          failures++;
          $display("FAIL fall_apply got ready=%b cur_half=%0d want 1/2", cfg_ready, cur_half);
        end
      end
      next_cyc();
    end
    go_idle();
    load_half(8'd4);
  endtask

  task automatic test_stop_high();
    phase_q = {5, 4, 8};
    push_wave();
    for (int k = 0; k < 17; k++) begin
      if (k == 0) en = 1'b1;
      if (k == 6) en = 1'b0;
      @(negedge clk);
      if (k == 8) begin
        checks++;
        if (running !== 1'b1) begin
          failures++;
          $display("FAIL stopping_running got=%b want=1", running);
        end
      end
      if (k >= 10 && k % 3 == 1) begin
        checks++;
        if (running !== 1'b0) begin
          failures++;
          $display("FAIL stopped_running cyc=%0d got=%b want=0", k, running);
        end
      end
      next_cyc();
    end
    go_idle();
  endtask

  task automatic test_stop_restart();
    phase_q = {5, 4, 4, 4, 4};
    push_wave();
    for (int k = 0; k < 21; k++) begin
      if (k == 0)  en = 1'b1;
      if (k == 6)  en = 1'b0;
      if (k == 7)  en = 1'b1;
      if (k == 10) en = 1'b0;
      if (k == 11) en = 1'b1;
      @(negedge clk);
      if (k == 12 || k == 20) begin
        checks++;
        if (running !== 1'b1) begin
          failures++;
          $display("FAIL restart_running cyc=%0d got=%b want=1", k, running);
        end
      end
      next_cyc();
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    phase_q = {5, 2};
    push_wave();
    for (int k = 0; k < 7; k++) begin
      if (k == 0) en = 1'b1;
      if (k == 6) begin
        cfg_half = 8'd7;
        cfg_valid = 1'b1;
      end
      @(negedge clk);
      next_cyc();
    end
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0 || clk_div !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset got ready=%b div=%b want 0/1", cfg_ready, clk_div);
    end
    rst = 1'b1;
    en = 1'b0;
    #1;
    checks++;
    if ({clk_div, running, cfg_ready, div_rise_stb, div_fall_stb} !== 5'b00100 ||
        cur_half !== 8'd4) begin
      failures++;
      $display("FAIL async_reset got div/run/ready/rise/fall=%b%b%b%b%b cur_half=%0d want 00100/4",
               clk_div, running, cfg_ready, div_rise_stb, div_fall_stb, cur_half);
    end
    next_cyc();
    next_cyc();
    rst = 1'b0;
    next_cyc();
    phase_q = {5, 4, 4};
    push_wave();
    for (int k = 0; k < 13; k++) begin
      if (k == 0) en = 1'b1;
      @(negedge clk);
      if (k == 12) begin
        checks++;
        if (cur_half !== 8'd4 || cfg_ready !== 1'b1) begin
          failures++;
          $display("FAIL discarded_cfg got cur_half=%0d ready=%b want 4/1", cur_half, cfg_ready);
        end
      end
      next_cyc();
    end
    go_idle();
  endtask

  task automatic test_cfg_zero();
`ifdef CLK_DIV_CTRL_CFG_ERR_EN
    phase_q = {7, 4, 4};
`else
    phase_q = {4, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
    push_wave();
    for (int k = 0; k < 15; k++) begin
      if (k == 0) begin
        cfg_half = 8'd0;
        cfg_valid = 1'b1;
      end
      if (k == 1) cfg_valid = 1'b0;
      if (k == 2) en = 1'b1;
      @(negedge clk);
`ifdef CLK_DIV_CTRL_CFG_ERR_EN
      if (k == 1 || k == 2) begin
        checks++;
        if (cfg_err !== (k == 1) || cfg_ready !== 1'b1) begin
          failures++;
          $display("FAIL zero_reject cyc=%0d got err=%b ready=%b want %b/1", k, cfg_err,
                   cfg_ready, (k == 1));
        end
      end
      if (k == 2 || k == 14) begin
        checks++;
        if (cur_half !== 8'd4) begin
          failures++;
          $display("FAIL zero_unchanged cyc=%0d got cur_half=%0d want=4", k, cur_half);
        end
      end
`else
      if (k == 1) begin
        checks++;
        if (cfg_ready !== 1'b0) begin
          failures++;
          $display("FAIL zero_pend got ready=%b want=0", cfg_ready);
        end
      end
      if (k == 2) begin
        checks++;
        if (cur_half !== 8'd1 || cfg_ready !== 1'b1) begin
          failures++;
          $display("FAIL zero_clamp got cur_half=%0d ready=%b want 1/1", cur_half, cfg_ready);
        end
      end
`endif
      next_cyc();
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    phase_q = {6, 3, 3, 3, 2, 2, 2};
    push_wave();
    for (int k = 0; k < 21; k++) begin
      if (k == 0) begin
        cfg_half = 8'd3;
        cfg_valid = 1'b1;
      end
      if (k == 1) cfg_valid = 1'b0;
      if (k == 2) en = 1'b1;
      if (k == 8) begin
        cfg_half = 8'd2;
        cfg_valid = 1'b1;
      end
      if (k == 9)  cfg_half = 8'd5;
      if (k == 14) cfg_valid = 1'b0;
      @(negedge clk);
      if (k == 9 || k == 14) begin
        checks++;
        if (cur_half !== 8'd3 || cfg_ready !== 1'b0) begin
          failures++;
          $display("FAIL same_fall_accept cyc=%0d got cur_half=%0d ready=%b want 3/0", k,
                   cur_half, cfg_ready);
        end
      end
      if (k == 15 || k == 20) begin
        checks++;
        if (cur_half !== 8'd2 || cfg_ready !== 1'b1) begin
          failures++;
          $display("FAIL next_fall_apply cyc=%0d got cur_half=%0d ready=%b want 2/1", k,
                   cur_half, cfg_ready);
        end
      end
      next_cyc();
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_run_basic();
    test_cfg_during_high();
    test_stop_high();
    test_stop_restart();
    test_reset_mid();
    test_cfg_zero();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d entries want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run/stop and ratio controller for the team's even clock divider function. Generates a 50%-duty divided clock `clk_div` plus single-cycle rise/fall strobes, with a half-period programmable at run time. A requester loads a new half-period through a valid/ready handshake; the controller applies it only at a falling edge of `clk_div`, so there is never a runt pulse. Used to sequence FFT stage timing from a single fast clock.

Parameters:
- HALF_W, 8: width of half-period count and config bus.
- HALF_DEF, 4: half-period after reset, in clk cycles. Legal range 1..2^HALF_W-1.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: run request; level sensitive.
- cfg_valid, input, 1: new half-period offered.
- cfg_half, input, HALF_W: requested half-period in clk cycles.
- cfg_ready, output, 1: controller can accept a config.
- clk_div, output, 1: divided clock, registered.
- div_rise_stb, output, 1: high for the one clk cycle in which clk_div first reads 1.
- div_fall_stb, output, 1: high for the one clk cycle in which clk_div first reads 0.
- running, output, 1: high in RUN and STOPPING.
- cur_half, output, HALF_W: half-period currently in effect.

Behaviour:
- Reset values, all asynchronous on rst=1:
  - clk_div=0, both strobes=0, running=0.
  - cfg_ready=1, cur_half=HALF_DEF.
  - cnt=0, pend_valid=0, state=IDLE.
- Counter:
  - In RUN/STOPPING, cnt increments each clk.
  - At cnt==cur_half-1: cnt wraps to 0 and clk_div toggles next cycle.
  - Period is 2*cur_half clk cycles; high and low phases are exactly cur_half each.
  - All registers are flops; strobes are registered alongside clk_div. No combinational path from inputs to outputs.
- FSM states: IDLE, RUN, STOPPING.
  - IDLE: clk_div=0, cnt held at 0. en=1 moves to RUN next cycle. First rising edge of clk_div occurs cur_half cycles after entering RUN.
  - RUN: en=0 moves to STOPPING.
  - STOPPING, clk_div=1: finish the high phase; clk_div falls (fall strobe asserted), then go to IDLE.
  - STOPPING, clk_div=0: go to IDLE next cycle and clear cnt. No extra edge is produced.
  - STOPPING, en=1 again before the stop completes: return to RUN with no disturbance to cnt or clk_div.
- Config handshake:
  - Transfer when cfg_valid && cfg_ready. The value is latched into pend_half, pend_valid is set, and cfg_ready drops the next cycle.
  - cfg_half==0 is clamped to 1.
  - Apply point in IDLE: the cycle after acceptance.
  - Apply point in RUN/STOPPING: the cycle in which clk_div toggles 1->0 (terminal count with clk_div=1). The new cur_half governs the low phase that follows.
  - On apply: pend_valid clears and cfg_ready returns to 1 on the next cycle.
  - An accept in the same cycle as a fall edge with nothing pending is applied at the next fall, not that one.
  - Only one config can be pending at a time; cfg_ready=0 blocks further offers.
- Reset mid-operation: all state returns to reset values immediately; any pending config is discarded.
- cur_half changes only at the defined apply points.

Optional Feature:
Macro CLK_DIV_CTRL_CFG_ERR_EN.
- Defined:
  - Adds output port cfg_err (1 bit, reset 0).
  - A handshake with cfg_half==0 is consumed (cfg_ready stays 1) but the value is rejected, not clamped.
  - cfg_err pulses high for one cycle; cur_half and pend_valid are unchanged.
- Undefined: no cfg_err port; a zero value is clamped to 1 as described in Behaviour.

Test Plan:
1. Reset release, en=1, HALF_DEF=4 -> first div_rise_stb 4 cycles after RUN entry; clk_div period 8 cycles; high phase exactly 4 cycles.
2. RUN with half=4, cfg_half=2 accepted during a high phase -> that high phase still lasts 4 cycles; next low phase lasts 2 cycles; cfg_ready returns 1 the cycle after the fall; cur_half reads 2.
3. en dropped at cycle 1 of a high phase (half=4) -> clk_div stays high 3 more cycles, then div_fall_stb; running=0 next; clk_div held 0 thereafter.
4. en dropped, then re-raised while in STOPPING -> no gap or phase change; period stays 2*cur_half.
5. rst pulsed mid high phase with a config pending -> clk_div=0 and cfg_ready=1 immediately; cur_half=HALF_DEF; pending value never applied.
6. cfg_half=0 in IDLE -> cur_half=1 and period 2 cycles after en. With CLK_DIV_CTRL_CFG_ERR_EN defined: one-cycle cfg_err pulse and cur_half unchanged.
